// File: rtl/attn_pkg.sv
// Shared types and defaults for the attention-engine score sequencer.
package attn_pkg;

    typedef enum logic [2:0] {
        Q_PHASE,
        K_PHASE,
        CAPTURE,
        NORM_START,
        NORM_WAIT,
        EMIT
    } attn_seq_state_t;

    localparam int ATTN_N_FEAT_DEF       = 4;
    localparam int ATTN_N_KEYS_DEF       = 4;
    localparam int ATTN_NORM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/attn_seq_ctrl_if.sv
// Stream, datapath-strobe and result handshake bundle for attn_seq_ctrl.
interface attn_seq_ctrl_if #(
    parameter int N_KEYS = 4
);
    localparam int KW = $clog2(N_KEYS);

    logic          s_vld;
    logic          s_rdy;
    logic          load_q;
    logic          mac_en;
    logic          ex_cap;
    logic          mac_clr;
    logic [KW-1:0] key_idx;
    logic          norm_start;
    logic          norm_done;
    logic          m_vld;
    logic          m_rdy;
    logic [KW-1:0] m_idx;
    logic          m_last;
    logic          err;

    // Environment side: byte source, normaliser and result sink.
    modport master (
        output s_vld, norm_done, m_rdy,
        input  s_rdy, load_q, mac_en, ex_cap, mac_clr, key_idx,
               norm_start, m_vld, m_idx, m_last, err
    );

    // Sequencer side.
    modport slave (
        input  s_vld, norm_done, m_rdy,
        output s_rdy, load_q, mac_en, ex_cap, mac_clr, key_idx,
               norm_start, m_vld, m_idx, m_last, err
    );
endinterface

// File: rtl/attn_wrap_cnt.sv
// Power-of-two wrapping counter with synchronous clear and terminal flag.
module attn_wrap_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign at_max = (cnt == '1);

endmodule

// File: rtl/attn_seq_ctrl.sv
// Score-datapath sequencer: q/k byte intake, capture strobes, normaliser hand-off, result emit.
// Optional normaliser timeout with sticky err: define ATTN_SEQ_TIMEOUT_EN.
module attn_seq_ctrl
    import attn_pkg::*;
#(
    parameter int N_FEAT       = ATTN_N_FEAT_DEF,
    parameter int N_KEYS       = ATTN_N_KEYS_DEF,
    parameter int NORM_TIMEOUT = ATTN_NORM_TIMEOUT_DEF
) (
    input logic            clk,
    input logic            rst_n,
    attn_seq_ctrl_if.slave bus
);

    localparam int FW = $clog2(N_FEAT);
    localparam int KW = $clog2(N_KEYS);

    attn_seq_state_t state, state_nx;

    logic [FW-1:0] feat_cnt;
    logic [KW-1:0] key_cnt;
    logic [KW-1:0] emit_cnt;
    logic          feat_last, key_last, emit_last;
    logic          to_hit;
    logic          err_q;

    attn_wrap_cnt #(.WIDTH(FW)) u_feat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (state == K_PHASE && bus.s_vld),
        .cnt    (feat_cnt),
        .at_max (feat_last)
    );

    attn_wrap_cnt #(.WIDTH(KW)) u_key_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (state == CAPTURE),
        .cnt    (key_cnt),
        .at_max (key_last)
    );

    attn_wrap_cnt #(.WIDTH(KW)) u_emit_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .inc    (state == EMIT && bus.m_rdy),
        .cnt    (emit_cnt),
        .at_max (emit_last)
    );

`ifdef ATTN_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(NORM_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    // Counter is zeroed while in NORM_START so each wait starts fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == NORM_START) begin
                to_cnt <= '0;
            end else if (state == NORM_WAIT && !bus.norm_done) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign to_hit = (state == NORM_WAIT) && !bus.norm_done &&
                    (to_cnt == TW'(NORM_TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
    assign err_q  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= Q_PHASE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            Q_PHASE:    if (bus.s_vld) state_nx = K_PHASE;
            K_PHASE:    if (bus.s_vld) state_nx = feat_last ? CAPTURE : Q_PHASE;
            CAPTURE:    state_nx = key_last ? NORM_START : Q_PHASE;
            NORM_START: state_nx = NORM_WAIT;
            NORM_WAIT:  if (bus.norm_done || to_hit) state_nx = EMIT;
            EMIT:       if (bus.m_rdy && emit_last) state_nx = Q_PHASE;
            default:    state_nx = Q_PHASE;
        endcase
    end

    always_comb begin
        bus.s_rdy      = (state == Q_PHASE) || (state == K_PHASE);
        bus.load_q     = (state == Q_PHASE) && bus.s_vld;
        bus.mac_en     = (state == K_PHASE) && bus.s_vld;
        bus.ex_cap     = (state == CAPTURE);
        bus.mac_clr    = (state == CAPTURE);
        bus.norm_start = (state == NORM_START);
        bus.m_vld      = (state == EMIT);
        bus.m_idx      = emit_cnt;
        bus.m_last     = (state == EMIT) && emit_last;
        bus.key_idx    = key_cnt;
        bus.err        = err_q;
    end

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// Directed table-driven bench for attn_seq_ctrl plus reset and timeout corner sequences.
module tb_attn_seq_ctrl;
    import attn_pkg::*;

    localparam int NF = 4;
    localparam int NK = 4;
`ifdef ATTN_SEQ_TIMEOUT_EN
    localparam int NT = 10;
`else
    localparam int NT = 255;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    attn_seq_ctrl_if #(.N_KEYS(NK)) bus ();

    attn_seq_ctrl #(.N_FEAT(NF), .N_KEYS(NK), .NORM_TIMEOUT(NT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {s_rdy, load_q, mac_en, ex_cap, mac_clr, norm_start, m_vld, m_idx[1:0], m_last, key_idx[1:0], err}
    typedef struct {
        logic        vld;
        logic        done;
        logic        rdy;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [12:0] ex(bit s_rdy, bit lq, bit me, bit cap, bit ns, bit mv,
                                       int mi, bit ml, int ki, bit er);
        logic [1:0] mi2, ki2;
        mi2 = mi[1:0];
        ki2 = ki[1:0];
        return {s_rdy, lq, me, cap, cap, ns, mv, mi2, ml, ki2, er};
    endfunction

    function automatic logic [12:0] act();
        return {bus.s_rdy, bus.load_q, bus.mac_en, bus.ex_cap, bus.mac_clr, bus.norm_start,
                bus.m_vld, bus.m_idx, bus.m_last, bus.key_idx, bus.err};
    endfunction

    task automatic chk(string name, logic [12:0] a, logic [12:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(bit v, bit d, bit r, logic [12:0] e);
        vec_t t;
        t.vld = v; t.done = d; t.rdy = r; t.exp = e;
        tbl.push_back(t);
    endfunction

    task automatic build_table();
        int idx[7];
        bit rp[7];
        idx = '{0, 1, 1, 1, 2, 3, 3};
        rp  = '{1, 0, 0, 1, 1, 0, 1};
        for (int k = 0; k < NK; k++) begin
            for (int f = 0; f < NF; f++) begin
                if (k == 2 && f == 0)
                    push(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, k, 0));
                push(1, 0, 0, ex(1, 1, 0, 0, 0, 0, 0, 0, k, 0));
                if (k == 1 && f == 2)
                    for (int g = 0; g < 3; g++)
                        push(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, k, 0));
                push(1, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, 0, k, 0));
            end
            push(1, 0, 0, ex(0, 0, 0, 1, 0, 0, 0, 0, k, 0));
        end
        // norm_done during NORM_START must be ignored
        push(1, 1, 0, ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int w = 0; w < 4; w++)
            push(1, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        push(1, 1, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int e = 0; e < 7; e++)
            push(1, 0, rp[e], ex(0, 0, 0, 0, 0, 1, idx[e], idx[e] == 3, 0, 0));
        push(0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_table(string tag);
        foreach (tbl[i]) begin
            bus.s_vld     = tbl[i].vld;
            bus.norm_done = tbl[i].done;
            bus.m_rdy     = tbl[i].rdy;
            #1;
            chk($sformatf("%s_vec%0d", tag, i), act(), tbl[i].exp);
            step();
        end
        bus.s_vld = 0; bus.norm_done = 0; bus.m_rdy = 0;
    endtask

    task automatic feed_row();
        bus.s_vld = 1;
        repeat (2 * NF * NK + NK) step();
        bus.s_vld = 0;
    endtask

    initial begin
        bus.s_vld = 0; bus.norm_done = 0; bus.m_rdy = 0;
        build_table();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        #1;
        chk("reset_state", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        run_table("row1");

        // Reset mid-row while building key 1
        bus.s_vld = 1;
        repeat (12) step();
        #1;
        chk("midrow_before_rst", act(), ex(1, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        rst_n = 0; bus.s_vld = 0;
        step();
        rst_n = 1;
        #1;
        chk("midrow_after_rst", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table("row2");

        // Reset during EMIT at m_idx=2
        feed_row();
        #1;
        chk("full_row_norm_start", act(), ex(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        step();
        bus.norm_done = 1;
        step();
        bus.norm_done = 0; bus.m_rdy = 1;
        step(); step();
        #1;
        chk("emit_idx2", act(), ex(0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
        rst_n = 0; bus.m_rdy = 0;
        step();
        rst_n = 1;
        #1;
        chk("emit_after_rst", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        #1;
        chk("emit_rst_no_vld", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table("row3");

        // Normaliser never answers
        feed_row();
        step();
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("wait_cyc%0d", i), act(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            step();
        end
`ifdef ATTN_SEQ_TIMEOUT_EN
        #1;
        chk("timeout_emit", act(), ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        bus.m_rdy = 1;
        repeat (4) step();
        bus.m_rdy = 0;
        #1;
        chk("err_sticky_q", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        feed_row();
        bus.norm_done = 1;
        step(); step();
        bus.norm_done = 0;
        #1;
        chk("err_sticky_emit", act(), ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("err_cleared", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
        repeat (20) step();
        #1;
        chk("wait_forever", act(), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.norm_done = 1;
        step();
        bus.norm_done = 0;
        #1;
        chk("late_done_emit", act(), ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        bus.m_rdy = 1;
        repeat (4) step();
        bus.m_rdy = 0;
        #1;
        chk("late_done_back_q", act(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/attn_seq_ctrl.md
# attn_seq_ctrl

Control sequencer for the credit-pipeline attention engine's score datapath (8×8 signed MAC → e^x → row sum → normalise). It owns the input valid/ready handshake for the interleaved q/k byte stream and counts features per dot product and keys per row. It emits one-cycle strobes that load, accumulate, capture and clear the datapath registers, then hands the finished row to the normaliser and paces result output through a master valid/ready handshake. It holds no datapath arithmetic itself.

## Interface
- `N_FEAT`, default 4: q·k pairs per dot product; power of two, ≥2.
- `N_KEYS`, default 4: scores per softmax row; power of two, ≥2.
- `NORM_TIMEOUT`, default 255: cycle limit for `norm_done`; used only with the timeout feature.
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_vld`  in  1  input byte valid.
- `s_rdy`  out  1  input byte ready.
- `load_q`  out  1  datapath latches the current byte as q operand.
- `mac_en`  out  1  datapath accumulates q×(current byte).
- `ex_cap`  out  1  shift e^x(mac) into the row register.
- `mac_clr`  out  1  clear the accumulator.
- `key_idx`  out  $clog2(N_KEYS)  index of the score currently being built.
- `norm_start`  out  1  one-cycle start pulse to the normaliser.
- `norm_done`  in  1  normaliser finished (level).
- `m_vld`  out  1  normalised output valid.
- `m_rdy`  in  1  downstream ready.
- `m_idx`  out  $clog2(N_KEYS)  index of the emitted element.
- `m_last`  out  1  high with the final element of the row.
- `err`  out  1  sticky normaliser timeout flag.

## Operation
- States: Q_PHASE, K_PHASE, CAPTURE, NORM_START, NORM_WAIT, EMIT.
- Q_PHASE: `s_rdy=1`; `load_q = s_vld`; on accept → K_PHASE.
- K_PHASE: `s_rdy=1`; `mac_en = s_vld`; on accept `feat_cnt++`. When the last feature is accepted (`feat_cnt==N_FEAT-1`) → CAPTURE, else → Q_PHASE. If `s_vld` is low, the block holds state; no timeout applies.
- CAPTURE (1 cycle): `s_rdy=0`; `ex_cap=1`, `mac_clr=1` in the same cycle; the datapath captures e^x of the old accumulator and clears it at the same edge. `key_cnt++`. If `key_cnt==N_KEYS-1` → NORM_START (`key_cnt` wraps to 0), else → Q_PHASE.
- NORM_START (1 cycle): `norm_start=1` → NORM_WAIT.
- NORM_WAIT: `norm_done` is sampled only in this state; when it is seen → EMIT.
- EMIT: `m_vld=1`, `m_idx=emit_cnt`, `m_last = (emit_cnt==N_KEYS-1)`. On `m_vld&m_rdy` the block advances `emit_cnt`. After the last element → Q_PHASE with `emit_cnt` wrapped to 0.
- `s_rdy`, `load_q` and `mac_en` are combinational from registered state and `s_vld`.
- All other outputs decode from registered state and counters only.
- `key_idx = key_cnt`. Counters wrap naturally at their power-of-two width.

## Timing
- Reset values: state=Q_PHASE and all counters 0. So `s_rdy=1` and every other output is 0, including `err` and `key_idx=0`.
- Reset mid-row, mid-normalise or mid-emit: the partial row is discarded; no `norm_start` or `m_vld` follows.
- Last k accepted at edge E → `ex_cap` high in cycle E+1 → `s_rdy` high again at E+2 (row not complete) or `norm_start` at E+2 (row complete).
- Best-case row throughput with `s_vld` held high: 2·N_FEAT·N_KEYS + N_KEYS input cycles, + 2 cycles, + normaliser latency, + N_KEYS emit cycles.
- `norm_done` asserted during NORM_START is ignored. It must be held or reasserted in NORM_WAIT.
- `m_rdy` high before `m_vld` is legal; the transfer occurs in the first EMIT cycle.
- `s_rdy` is low throughout CAPTURE, NORM_*, EMIT. Input never overlaps output.

## Configuration
- `ATTN_SEQ_TIMEOUT_EN` defined:
  - An 8-bit (`$clog2(NORM_TIMEOUT+1)`) counter runs in NORM_WAIT, cleared on entry.
  - If it reaches `NORM_TIMEOUT` without `norm_done`, `err` sets (cleared only by reset) and the FSM proceeds to EMIT.
- Undefined: `err` is tied 0, no counter is built, and NORM_WAIT waits indefinitely.

## Structure
- The shared package `attn_pkg` holds:
  - the state enum `attn_seq_state_t`;
  - localparams `ATTN_N_FEAT_DEF=4`, `ATTN_N_KEYS_DEF=4`, `ATTN_NORM_TIMEOUT_DEF=255`.
- One sub-module, `attn_wrap_cnt` (parameter WIDTH; ports: clk, rst_n, clr, inc, cnt, at_max), is instantiated for the feat, key and emit counters.

## Test plan
- Reset, defaults: `s_vld=1` streaming bytes → `load_q`/`mac_en` alternate. `ex_cap`+`mac_clr` pulse 1 cycle after every 8th accepted byte. `key_idx` steps 0→1→2→3.
- Row completion: after 32 accepted bytes → `norm_start` single pulse 2 cycles after the last accept. `s_rdy=0` until EMIT ends.
- Gapped input: `s_vld` low 3 cycles between q and k → FSM holds K_PHASE, no `mac_en`, and the accumulation count stays exact.
- Emit backpressure: `norm_done` at cycle +5; `m_rdy` toggles 1,0,0,1,1,0,1 → `m_idx` 0..3 each transferred once, `m_last` only with idx 3. `s_rdy` returns the cycle after the last transfer.
- Reset during EMIT at `m_idx=2` → next cycle `m_vld=0`, `s_rdy=1`, `key_idx=0`; the next row behaves normally.
- `ATTN_SEQ_TIMEOUT_EN`, `NORM_TIMEOUT=10`, `norm_done` never → `err=1` after 10 NORM_WAIT cycles, EMIT proceeds. `err` stays 1 through the next row until reset.
